// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - command encodings and FSM state type shared by the SPI master and slave sides
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_TURN    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_GAP     = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - command/readback bus plus SPI pins of the SPI master controller
interface spi_master_ctrl_if #(parameter int ADDR_SIZE = 8);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_type;
  logic [ADDR_SIZE-1:0] cmd_data;
  logic                 rd_valid;
  logic [ADDR_SIZE-1:0] rd_data;
  logic                 busy;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;

  modport master (
    input  cmd_valid, cmd_type, cmd_data, MISO,
    output cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_data, MISO,
    input  cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
  );

endinterface

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parallel-load shift register, serial in at LSB, serial out at MSB
module spi_shift_reg #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], i_sin};
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_q[WIDTH-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - serializes {cmd_type, cmd_data} onto MOSI and captures read data from MISO
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int RD_WAIT   = 2,
  parameter int GAP       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);

  localparam int         W_WIDTH    = ADDR_SIZE + 2;
  localparam logic [3:0] SHIFT_LAST = 4'(W_WIDTH - 1);
  localparam logic [3:0] TURN_LAST  = 4'(RD_WAIT - 1);
  localparam logic [3:0] CAPT_LAST  = 4'(ADDR_SIZE - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);
  localparam spi_state_t ST_DONE    = (GAP == 0) ? ST_IDLE : ST_GAP;
  localparam spi_state_t ST_RD_NEXT = (RD_WAIT == 0) ? ST_CAPTURE : ST_TURN;

  spi_state_t         r_state, w_next;
  logic [3:0]         r_cnt;
  logic               r_is_rd;
  logic               r_ss_n, r_mosi, r_cmd_ready, r_busy, r_rd_valid;
  logic               w_accept, w_last, w_mosi_next, w_shift_w, w_capture;
  logic [W_WIDTH-1:0] w_word_q, w_rd_q;
  logic               w_word_sout, w_rd_sout;
  logic               w_unused;

  assign w_accept  = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_capture = (r_state == ST_CAPTURE);

  spi_shift_reg #(.WIDTH(W_WIDTH)) u_word (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_load_data ({bus.cmd_type, bus.cmd_data}),
    .i_shift     (w_shift_w),
    .i_sin       (1'b0),
    .o_q         (w_word_q),
    .o_sout      (w_word_sout)
  );

  spi_shift_reg #(.WIDTH(W_WIDTH)) u_rd (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_capture),
    .i_sin       (bus.MISO),
    .o_q         (w_rd_q),
    .o_sout      (w_rd_sout)
  );

  assign w_unused = ^{w_word_q[W_WIDTH-1], w_word_q[W_WIDTH-3:0],
                      w_rd_q[W_WIDTH-1:ADDR_SIZE], w_rd_sout};

  // MOSI is registered from the next state, so the bit queued here is the one the slave sees next cycle
  always_comb begin
    w_next      = r_state;
    w_mosi_next = 1'b0;
    w_shift_w   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_next      = ST_LEAD;
          w_mosi_next = bus.cmd_type[1];
        end
      end
      ST_LEAD: begin
        w_last      = 1'b1;
        w_next      = ST_SHIFT;
        w_mosi_next = w_word_sout;
      end
      ST_SHIFT: begin
        w_last = (r_cnt == SHIFT_LAST);
        if (w_last) begin
          w_next = r_is_rd ? ST_RD_NEXT : ST_DONE;
        end else begin
          w_mosi_next = w_word_q[W_WIDTH-2];
          w_shift_w   = 1'b1;
        end
      end
      ST_TURN: begin
        w_last = (r_cnt == TURN_LAST);
        if (w_last) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_last = (r_cnt == CAPT_LAST);
        if (w_last) w_next = ST_DONE;
      end
      ST_GAP: begin
        w_last = (r_cnt == GAP_LAST);
        if (w_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_is_rd     <= 1'b0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter is cleared on every state entry and held at zero in IDLE so it never wraps
      if ((w_next != r_state) || (r_state == ST_IDLE)) r_cnt <= 4'd0;
      else                                             r_cnt <= r_cnt + 4'd1;
      if (w_accept) r_is_rd <= (bus.cmd_type == CMD_RD_DATA);
      r_ss_n      <= (w_next == ST_IDLE) || (w_next == ST_GAP);
      r_mosi      <= w_mosi_next;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_busy      <= (w_next != ST_IDLE);
      r_rd_valid  <= w_capture && w_last;
    end
  end

  assign bus.SS_n      = r_ss_n;
  assign bus.MOSI      = r_mosi;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = r_busy;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = w_rd_q[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - bench for spi_master_ctrl with a behavioural SPI wrapper and memory reference
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int ADDR_SIZE = 8;
  localparam int RD_WAIT   = 2;
  localparam int GAP       = 1;
  localparam int WR_LEN    = 11;
  localparam int RD_LEN    = 11 + RD_WAIT + 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.ADDR_SIZE(ADDR_SIZE)) bus();

  spi_master_ctrl #(.ADDR_SIZE(ADDR_SIZE), .RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int len; logic lead; logic [9:0] word; int gap; int bad;} txn_t;
  typedef struct {logic [7:0] data; int idx;} rv_t;

  txn_t       txq[$];
  rv_t        rvq[$];
  logic [9:0] expq[$];
  logic [7:0] exprd[$];

  int n_checks = 0, n_pass = 0, n_fail = 0;

  logic [7:0] smem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] s_wr = 8'h00, s_rd = 8'h00, m_wr = 8'h00, m_rd = 8'h00;

  int low_i = 0, high_i = 0, cur_gap = 0, cur_bad = 0, idle_bad = 0;
  logic       lead_bit = 1'b0;
  logic [9:0] w_sh = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // SPI wrapper model: decodes frames seen on the pins and answers read-data from its memory
  always @(negedge clk) begin
    int k;
    if (bus.rd_valid === 1'b1)
      rvq.push_back(rv_t'{bus.rd_data, (bus.SS_n === 1'b1) ? high_i : -1});
    if (bus.SS_n === 1'b0) begin
      if (low_i == 0) begin
        cur_gap  = high_i;
        cur_bad  = 0;
        lead_bit = bus.MOSI;
        w_sh     = '0;
      end else if (low_i <= 10) begin
        w_sh = {w_sh[8:0], bus.MOSI};
      end else if (bus.MOSI !== 1'b0) begin
        cur_bad++;
      end
      k = low_i - (11 + RD_WAIT);
      low_i++;
      high_i = 0;
      if (k >= 0 && k < 8 && w_sh[9:8] == CMD_RD_DATA) bus.MISO = smem[s_rd][7-k];
      else                                             bus.MISO = 1'($urandom_range(0, 1));
    end else begin
      if (bus.MOSI !== 1'b0) idle_bad++;
      if (low_i > 0) begin
        txq.push_back(txn_t'{low_i, lead_bit, w_sh, cur_gap, cur_bad});
        if (low_i >= 11) begin
          case (w_sh[9:8])
            CMD_WR_ADDR: s_wr = w_sh[7:0];
            CMD_WR_DATA: smem[s_wr] = w_sh[7:0];
            CMD_RD_ADDR: s_rd = w_sh[7:0];
            default: ;
          endcase
        end
      end
      low_i = 0;
      high_i++;
    end
  end

  task automatic model(input logic [1:0] t, input logic [7:0] d);
    expq.push_back({t, d});
    case (t)
      CMD_WR_ADDR: m_wr = d;
      CMD_WR_DATA: ref_mem[m_wr] = d;
      CMD_RD_ADDR: m_rd = d;
      default:     exprd.push_back(ref_mem[m_rd]);
    endcase
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) timeout_fail("cmd_ready_wait");
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_data  = d;
    model(t, d);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'($urandom);
    bus.cmd_data  = 8'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("ready_after_accept", 32'(bus.cmd_ready), 32'd0);
    check("ss_low_after_accept", 32'(bus.SS_n), 32'd0);
  endtask

  task automatic verify();
    int n = expq.size();
    int w = 0;
    txn_t t;
    rv_t r;
    logic [9:0] e;
    while (txq.size() < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) timeout_fail("txn_wait");
    repeat (4) @(negedge clk);
    check("txn_count", txq.size(), n);
    for (int i = 0; i < n && txq.size() > 0; i++) begin
      t = txq.pop_front();
      e = expq[i];
      check("ss_low_len", t.len, (e[9:8] == CMD_RD_DATA) ? RD_LEN : WR_LEN);
      check("lead_bit", 32'(t.lead), 32'(e[9]));
      check("mosi_word", 32'(t.word), 32'(e));
      check("turn_capture_mosi", t.bad, 0);
      if (i > 0) check("ss_high_gap", t.gap, GAP + 1);
    end
    check("mosi_idle", idle_bad, 0);
    check("rd_pulses", rvq.size(), exprd.size());
    while (rvq.size() > 0 && exprd.size() > 0) begin
      r = rvq.pop_front();
      check("rd_data", 32'(r.data), 32'(exprd.pop_front()));
      check("rd_valid_pos", r.idx, 0);
    end
    txq.delete();
    rvq.delete();
    expq.delete();
    exprd.delete();
  endtask

  initial begin
    logic [7:0] a, d, v;
    int acc, w;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'b00;
    bus.cmd_data  = 8'h00;
    bus.MISO      = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      smem[i]    = v;
      ref_mem[i] = v;
    end
    smem[4]    = 8'hA5;
    ref_mem[4] = 8'hA5;

    #1 rst_n = 1'b0;
    #3;
    check("rst_ss_n", 32'(bus.SS_n), 32'd1);
    check("rst_mosi", 32'(bus.MOSI), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy_after", 32'(bus.busy), 32'd0);

    send(CMD_RD_ADDR, 8'h04);
    send(CMD_RD_DATA, 8'($urandom));
    verify();

    send(CMD_WR_ADDR, 8'h04);
    send(CMD_WR_DATA, 8'h14);
    verify();
    check("rd_data_hold", 32'(bus.rd_data), 32'hA5);

    repeat (6) begin
      a = 8'($urandom);
      d = 8'($urandom);
      send(CMD_WR_ADDR, a);
      send(CMD_WR_DATA, d);
      send(CMD_RD_ADDR, a);
      send(CMD_RD_DATA, 8'($urandom));
      send(2'($urandom), 8'($urandom));
      verify();
    end

    // cmd_valid held high with payload changing every cycle
    acc = 0;
    w   = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    while (acc < 4 && w < 500) begin
      bus.cmd_type = 2'($urandom);
      bus.cmd_data = 8'($urandom);
      if (bus.cmd_ready === 1'b1) begin
        model(bus.cmd_type, bus.cmd_data);
        acc++;
      end
      if (acc < 4) @(negedge clk);
      w++;
    end
    if (w >= 500) timeout_fail("hold_valid_accepts");
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    verify();

    // reset during SHIFT bit 5 of a read-data frame
    send(CMD_RD_DATA, 8'($urandom));
    w = 0;
    while (low_i != 6 && w < 50) begin
      @(posedge clk);
      w++;
    end
    if (w >= 50) timeout_fail("shift_bit5_wait");
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss_n_async", 32'(bus.SS_n), 32'd1);
    check("abort_mosi", 32'(bus.MOSI), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_rd_data", 32'(bus.rd_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txq.delete();
    rvq.delete();
    expq.delete();
    exprd.delete();
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    send(CMD_WR_ADDR, 8'h7F);
    repeat (20) @(negedge clk);
    verify();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 8, meaning the payload width in bits of a command word.
REQ-002 The block SHALL have parameter RD_WAIT, default 2, meaning the number of turnaround cycles between the last MOSI bit and the first MISO sample of a read-data transaction.
REQ-003 The block SHALL have parameter GAP, default 1, meaning the minimum number of cycles SS_n stays high between transactions.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: high when the block can accept a command.
REQ-008 The block SHALL have port cmd_type, input, 2 bits: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-009 The block SHALL have port cmd_data, input, ADDR_SIZE bits: the address or data payload.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: a one-cycle pulse marking rd_data valid.
REQ-011 The block SHALL have port rd_data, output, ADDR_SIZE bits: the byte captured from MISO.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have ports SS_n (output, 1), MOSI (output, 1) and MISO (input, 1), which connect directly to the SPI slave wrapper.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL be high only in IDLE.
REQ-015 On acceptance, the block SHALL latch {cmd_type, cmd_data} as a 10-bit word W (ADDR_SIZE+2 bits) and move to LEAD.
REQ-016 FSM states SHALL be IDLE, LEAD, SHIFT, TURN, CAPTURE and GAP, with all outputs registered.
REQ-017 In LEAD (1 cycle), SS_n SHALL be 0 and MOSI SHALL be W[9], which gives the slave its command-check cycle.
REQ-018 In SHIFT (ADDR_SIZE+2 cycles), the block SHALL drive MOSI with W[9] down to W[0], MSB first, one bit per cycle, with SS_n held at 0.
REQ-019 After SHIFT, cmd_type 00, 01 or 10 SHALL go to GAP; cmd_type 11 SHALL go to TURN.
REQ-020 In TURN (RD_WAIT cycles), SS_n SHALL be 0 and MOSI SHALL be 0.
REQ-021 In CAPTURE (ADDR_SIZE cycles), the block SHALL shift MISO into rd_data MSB first, sampling at each rising edge.
REQ-022 rd_valid SHALL pulse high for exactly one cycle, starting the cycle after the last sample, and rd_data SHALL hold its value until the next capture.
REQ-023 In GAP (GAP cycles), SS_n SHALL be 1 and MOSI SHALL be 0; the block SHALL then return to IDLE.
REQ-024 In IDLE, SS_n SHALL be 1 and MOSI SHALL be 0.
REQ-025 cmd_valid asserted while busy SHALL be ignored, with no effect on the current transaction.
REQ-026 Back-to-back commands SHALL be separated by exactly GAP+1 cycles of SS_n high (GAP, then one IDLE cycle).
REQ-027 Total SS_n-low time SHALL be 11 cycles for cmd_type 00, 01 and 10, and 11+RD_WAIT+8 cycles for cmd_type 11.
REQ-028 The bit counter SHALL be 4 bits wide, SHALL restart at each state entry, and SHALL never wrap within a state.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: state IDLE, SS_n=1, MOSI=0, cmd_ready=1 (after release), busy=0, rd_valid=0, rd_data=0, counters=0.
REQ-030 A reset in the middle of a transaction SHALL abort it with no rd_valid pulse; the first command after release SHALL start a clean LEAD.

Structure
REQ-031 Package spi_pkg SHALL hold the cmd_type encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the FSM state encoding, shared with the slave side.
REQ-032 One sub-module, spi_shift_reg, SHALL be used: a parallel-load, serial-out/serial-in register, ADDR_SIZE+2 bits wide, with a shift enable, used for both W and rd_data.

Verification
REQ-033 Write-address 0x04 -> MOSI shows lead 0, then 00_0000_0100; SS_n is low for 11 cycles, then high for GAP; no rd_valid.
REQ-034 Write-data 0x14 immediately after -> the second transaction starts exactly GAP+1 cycles after the first SS_n rise, and MOSI shows 01_0001_0100.
REQ-035 Read-address 0x04 followed by read-data, with the SPI_Wrapper holding 0xA5 at mem[0x04] -> rd_data=0xA5, with a single rd_valid pulse at SS_n-low cycle 11+RD_WAIT+8.
REQ-036 cmd_valid held high continuously with changing cmd_data during a transaction -> only the first command is serialized, and each later accept aligns with cmd_ready.
REQ-037 rst_n pulsed low at SHIFT bit 5 of a read-data transaction -> SS_n goes to 1 asynchronously, there is no rd_valid, and the next write-address 0x7F serializes correctly.
